// File: rtl/pair_loader.sv
// Collects two accepted words into d1/d2 and pulses en for one cycle when the pair is complete.
// First en follows the second accept by one edge; in_ready is simply !flush (never stalls otherwise).
module pair_loader #(
  parameter int size = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [size-1:0] in_data,
  output logic            in_ready,
  input  logic            flush,
  output logic [size-1:0] d1,
  output logic [size-1:0] d2,
  output logic            en,
  output logic [7:0]      pair_count,
  output logic            partial
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [size-1:0] d1_q, d1_d;
  logic [size-1:0] d2_q, d2_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            accept;

  // flush blocks acceptance, so no capture can coincide with a flush
  assign accept = in_valid & ~flush;

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          d1_d    = in_data;
          state_d = HALF;
        end
      end
      HALF: begin
        if (accept) begin
          d2_d    = in_data;
          cnt_d   = cnt_q + 8'd1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          d1_d    = in_data;
          state_d = HALF;
        end else begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d1_q    <= '0;
      d2_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = ~flush;
  assign en         = (state_q == FULL);
  assign partial    = (state_q == HALF);
  assign d1         = d1_q;
  assign d2         = d2_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_pair_loader.sv
// Directed bench for pair_loader with size=4; inputs driven 1ns after posedge, outputs checked there too.
module tb_pair_loader;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic         en;
  logic [7:0]   pair_count;
  logic         partial;

  int checks;
  int errors;

  pair_loader #(.size(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .d1         (d1),
    .d2         (d2),
    .en         (en),
    .pair_count (pair_count),
    .partial    (partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'hF;
    flush    = 1'b0;
    #2;
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", en); end
    checks++; if (partial !== 1'b0) begin errors++; $display("FAIL reset_partial got %b want 0", partial); end
    checks++; if (d1 !== 4'h0 || d2 !== 4'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", d1, d2); end
    checks++; if (pair_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pair_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    step();
    checks++; if (partial !== 1'b0) begin errors++; $display("FAIL reset_hold_partial got %b want 0", partial); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_flush got %b want 0", in_ready); end
    flush = 1'b0;
  endtask

  task automatic test_basic_pair();
    do_reset();
    in_valid = 1'b1; in_data = 4'd3;
    step();
    checks++; if (partial !== 1'b1 || en !== 1'b0 || d1 !== 4'd3) begin
      errors++; $display("FAIL basic_half got partial=%b en=%b d1=%0d want 1 0 3", partial, en, d1); end
    in_data = 4'd5;
    step();
    checks++; if (en !== 1'b1 || d1 !== 4'd3 || d2 !== 4'd5 || pair_count !== 8'd1) begin
      errors++; $display("FAIL basic_full got en=%b d1=%0d d2=%0d cnt=%0d want 1 3 5 1", en, d1, d2, pair_count); end
    checks++; if (partial !== 1'b0) begin errors++; $display("FAIL basic_full_partial got %b want 0", partial); end
    in_valid = 1'b0; in_data = 4'hE;
    step();
    checks++; if (en !== 1'b0 || partial !== 1'b0 || d1 !== 4'd3 || d2 !== 4'd5) begin
      errors++; $display("FAIL basic_empty got en=%b partial=%b d1=%0d d2=%0d want 0 0 3 5", en, partial, d1, d2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_idle got %b want 1", in_ready); end
  endtask

  task automatic test_hold_invalid();
    do_reset();
    in_valid = 1'b1; in_data = 4'd6;
    step();
    in_valid = 1'b0; in_data = 4'd9;
    step();
    step();
    checks++; if (partial !== 1'b1 || en !== 1'b0 || d1 !== 4'd6 || d2 !== 4'd0) begin
      errors++; $display("FAIL hold_half got partial=%b en=%b d1=%0d d2=%0d want 1 0 6 0", partial, en, d1, d2); end
    in_valid = 1'b1; in_data = 4'd10;
    step();
    checks++; if (en !== 1'b1 || d1 !== 4'd6 || d2 !== 4'd10) begin
      errors++; $display("FAIL hold_pair got en=%b d1=%0d d2=%0d want 1 6 10", en, d1, d2); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_d1;
    logic [W-1:0] exp_d2;
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_data = 4'(i);
      step();
      if (i % 2 == 0) begin
        exp_d1 = 4'(i - 1);
        exp_d2 = 4'(i);
        checks++; if (en !== 1'b1 || d1 !== exp_d1 || d2 !== exp_d2) begin
          errors++; $display("FAIL b2b_pair%0d got en=%b d1=%0d d2=%0d want 1 %0d %0d", i / 2, en, d1, d2, exp_d1, exp_d2); end
      end else begin
        checks++; if (en !== 1'b0 || partial !== 1'b1) begin
          errors++; $display("FAIL b2b_gap%0d got en=%b partial=%b want 0 1", i, en, partial); end
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (pair_count !== 8'd3 || en !== 1'b0) begin
      errors++; $display("FAIL b2b_count got cnt=%0d en=%b want 3 0", pair_count, en); end
  endtask

  task automatic test_flush_half();
    do_reset();
    in_valid = 1'b1; in_data = 4'd9;
    step();
    checks++; if (partial !== 1'b1 || d1 !== 4'd9) begin
      errors++; $display("FAIL flushh_load got partial=%b d1=%0d want 1 9", partial, d1); end
    flush = 1'b1; in_data = 4'd10;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flushh_ready got %b want 0", in_ready); end
    step();
    checks++; if (partial !== 1'b0 || en !== 1'b0 || d1 !== 4'd9 || pair_count !== 8'd0) begin
      errors++; $display("FAIL flushh_drop got partial=%b en=%b d1=%0d cnt=%0d want 0 0 9 0", partial, en, d1, pair_count); end
    flush = 1'b0; in_data = 4'd7;
    step();
    checks++; if (partial !== 1'b1 || en !== 1'b0 || d1 !== 4'd7) begin
      errors++; $display("FAIL flushh_restart got partial=%b en=%b d1=%0d want 1 0 7", partial, en, d1); end
    in_data = 4'd8;
    step();
    checks++; if (en !== 1'b1 || d1 !== 4'd7 || d2 !== 4'd8 || pair_count !== 8'd1) begin
      errors++; $display("FAIL flushh_pair got en=%b d1=%0d d2=%0d cnt=%0d want 1 7 8 1", en, d1, d2, pair_count); end
  endtask

  // continues from the FULL state left by test_flush_half
  task automatic test_flush_full();
    flush = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    #1;
    checks++; if (en !== 1'b1 || in_ready !== 1'b0 || d1 !== 4'd7 || d2 !== 4'd8) begin
      errors++; $display("FAIL flushf_en got en=%b rdy=%b d1=%0d d2=%0d want 1 0 7 8", en, in_ready, d1, d2); end
    step();
    checks++; if (en !== 1'b0 || partial !== 1'b0 || d1 !== 4'd7 || pair_count !== 8'd1) begin
      errors++; $display("FAIL flushf_empty got en=%b partial=%b d1=%0d cnt=%0d want 0 0 7 1", en, partial, d1, pair_count); end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_count_wrap();
    logic [7:0] exp_cnt;
    do_reset();
    in_valid = 1'b1;
    for (int p = 1; p <= 257; p++) begin
      in_data = 4'(2 * p);
      step();
      in_data = 4'(2 * p + 1);
      step();
      exp_cnt = 8'(p);
      if (p == 255 || p == 256 || p == 257) begin
        checks++; if (en !== 1'b1 || pair_count !== exp_cnt) begin
          errors++; $display("FAIL wrap_pair%0d got en=%b cnt=%0d want 1 %0d", p, en, pair_count, exp_cnt); end
      end
    end
    checks++; if (d1 !== 4'(2 * 257) || d2 !== 4'(2 * 257 + 1)) begin
      errors++; $display("FAIL wrap_data got d1=%0d d2=%0d want %0d %0d", d1, d2, 4'(2 * 257), 4'(2 * 257 + 1)); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    in_data = 4'd1; step();
    in_data = 4'd2; step();
    in_data = 4'd12; step();
    in_valid = 1'b0;
    checks++; if (partial !== 1'b1 || pair_count !== 8'd1 || d1 !== 4'd12) begin
      errors++; $display("FAIL areset_setup got partial=%b cnt=%0d d1=%0d want 1 1 12", partial, pair_count, d1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (partial !== 1'b0 || en !== 1'b0 || d1 !== 4'd0 || d2 !== 4'd0 || pair_count !== 8'd0) begin
      errors++; $display("FAIL areset_clear got partial=%b en=%b d1=%0d d2=%0d cnt=%0d want all 0", partial, en, d1, d2, pair_count); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (en !== 1'b0 || partial !== 1'b0) begin
      errors++; $display("FAIL areset_noen got en=%b partial=%b want 0 0", en, partial); end
    in_valid = 1'b1; in_data = 4'd6;
    step();
    checks++; if (partial !== 1'b1 || d1 !== 4'd6) begin
      errors++; $display("FAIL areset_first got partial=%b d1=%0d want 1 6", partial, d1); end
    in_data = 4'd9;
    step();
    checks++; if (en !== 1'b1 || d1 !== 4'd6 || d2 !== 4'd9 || pair_count !== 8'd1) begin
      errors++; $display("FAIL areset_pair got en=%b d1=%0d d2=%0d cnt=%0d want 1 6 9 1", en, d1, d2, pair_count); end
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    test_reset();
    test_basic_pair();
    test_hold_invalid();
    test_back_to_back();
    test_flush_half();
    test_flush_full();
    test_count_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
